// File: rtl/mem_arbiter_if.sv
// Line-refill / write-back port shared by the caches, the arbiter and memory.
// A requester holds read or write (level) with addr/wdata until it sees a
// one-cycle ready pulse; rdata is valid together with ready.
//   master : drives read, write, addr, wdata; receives rdata, ready
//   slave  : receives read, write, addr, wdata; drives rdata, ready
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) ();
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line memory port between I-cache and D-cache.
// The winning command is registered onto the memory port and the memory ready
// pulse is forwarded only to the owning client.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_port     : I-cache request port (slave)
//   d_port     : D-cache request port (slave)
//   mem_port   : memory command port (master)
//   busy       : high whenever the arbiter is not idle
//
// state | meaning
// IDLE  | no transaction; sample requests and grant
// GNT_I | I-cache owns memory, waiting for mem_ready
// GNT_D | D-cache owns memory, waiting for mem_ready
// REL   | command deasserted for one cycle so the owner can drop its request
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  i_port,
    mem_arbiter_if.slave  d_port,
    mem_arbiter_if.master mem_port,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, REL} state_t;

    state_t            state_q, state_d;
    logic              last_d_q;   // 1: D was granted last, so I wins a tie
    logic              read_q, write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              i_req, d_req;
    logic              grant_i, grant_d;

    assign i_req = i_port.read | i_port.write;
    assign d_req = d_port.read | d_port.write;

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_d_q) grant_i = 1'b1;
                    else          grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      state_d = GNT_I;
                else if (grant_d) state_d = GNT_D;
            end
            GNT_I, GNT_D: begin
                if (mem_port.ready) state_d = REL;
            end
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read+write together is executed as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i) begin
                addr_q   <= i_port.addr;
                wdata_q  <= i_port.wdata;
                write_q  <= i_port.write;
                read_q   <= i_port.read & ~i_port.write;
                last_d_q <= 1'b0;
            end else if (grant_d) begin
                addr_q   <= d_port.addr;
                wdata_q  <= d_port.wdata;
                write_q  <= d_port.write;
                read_q   <= d_port.read & ~d_port.write;
                last_d_q <= 1'b1;
            end else if (state_d == REL) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
            end
        end
    end

    assign mem_port.read  = read_q;
    assign mem_port.write = write_q;
    assign mem_port.addr  = addr_q;
    assign mem_port.wdata = wdata_q;

    assign i_port.rdata = mem_port.rdata;
    assign d_port.rdata = mem_port.rdata;
    assign i_port.ready = (state_q == GNT_I) & mem_port.ready;
    assign d_port.ready = (state_q == GNT_D) & mem_port.ready;

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level ownership model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    mem_arbiter_if i_if ();
    mem_arbiter_if d_if ();
    mem_arbiter_if mem_if ();

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_port   (i_if),
        .d_port   (d_if),
        .mem_port (mem_if),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns memory (0 none, 1 I, 2 D), cycles left in release,
    // which client was granted last, and the command memory should see.
    int           m_owner;
    int           m_cool;
    bit           m_last_d;
    bit           m_wr;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata;
    bit           i_done, d_done;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_cool   = 0;
        m_last_d = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
    endtask

    // Called at a falling edge with inputs already applied: checks outputs,
    // advances the model across the rising edge, returns at the next falling edge.
    task automatic step();
        int  win;
        bit  ir, dr;
        #1;
        chk("mem_read",  mem_if.read,  (m_owner != 0) && !m_wr);
        chk("mem_write", mem_if.write, (m_owner != 0) && m_wr);
        chk("mem_addr",  mem_if.addr,  m_addr);
        chk("mem_wdata", mem_if.wdata, m_wdata);
        chk("busy",      busy,         (m_owner != 0) || (m_cool != 0));
        chk("i_ready",   i_if.ready,   (m_owner == 1) && mem_if.ready);
        chk("d_ready",   d_if.ready,   (m_owner == 2) && mem_if.ready);
        chk("i_rdata",   i_if.rdata,   mem_if.rdata);
        chk("d_rdata",   d_if.rdata,   mem_if.rdata);
        i_done = i_if.ready;
        d_done = d_if.ready;
        @(posedge clk);
        if (m_owner != 0) begin
            if (mem_if.ready) begin
                m_owner = 0;
                m_cool  = 1;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else begin
            ir  = i_if.read | i_if.write;
            dr  = d_if.read | d_if.write;
            win = 0;
            if (ir && dr) win = m_last_d ? 1 : 2;
            else if (ir)  win = 1;
            else if (dr)  win = 2;
            if (win == 1) begin
                m_wr = i_if.write; m_addr = i_if.addr; m_wdata = i_if.wdata;
            end else if (win == 2) begin
                m_wr = d_if.write; m_addr = d_if.addr; m_wdata = d_if.wdata;
            end
            if (win != 0) begin
                m_owner  = win;
                m_last_d = (win == 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic serve(int lat, logic [127:0] rd);
        mem_if.ready = 1'b0;
        repeat (lat) step();
        mem_if.ready = 1'b1;
        mem_if.rdata = rd;
        step();
        mem_if.ready = 1'b0;
    endtask

    task automatic clear_clients();
        i_if.read = 1'b0; i_if.write = 1'b0;
        d_if.read = 1'b0; d_if.write = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_read",  mem_if.read,  1'b0);
        chk("rst_mem_write", mem_if.write, 1'b0);
        chk("rst_busy",      busy,         1'b0);
        chk("rst_i_ready",   i_if.ready,   1'b0);
        chk("rst_d_ready",   d_if.ready,   1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_clients();
        i_if.addr = '0; i_if.wdata = '0;
        d_if.addr = '0; d_if.wdata = '0;
        mem_if.ready = 1'b0;
        mem_if.rdata = '0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_mem_addr",  mem_if.addr,  28'h0);
        chk("rst_mem_wdata", mem_if.wdata, 128'h0);
        chk("rst_busy",      busy,         1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single D read
        d_if.read = 1'b1; d_if.addr = 28'h0000123;
        step();
        chk("single_d_read", mem_if.read, 1'b1);
        chk("single_d_addr", mem_if.addr, 28'h0000123);
        serve(3, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        clear_clients();
        step();
        step();

        // simultaneous first requests after reset: D wins
        do_reset();
        i_if.read = 1'b1;  i_if.addr = 28'h0AAA000;
        d_if.write = 1'b1; d_if.addr = 28'h0BBB000; d_if.wdata = 128'h1111;
        step();
        chk("tie_d_write", mem_if.write, 1'b1);
        chk("tie_d_addr",  mem_if.addr,  28'h0BBB000);
        serve(2, 128'h22);
        d_if.write = 1'b0;
        step();
        step();
        chk("tie_i_read", mem_if.read, 1'b1);
        chk("tie_i_addr", mem_if.addr, 28'h0AAA000);
        serve(1, 128'h33);
        clear_clients();
        step();
        step();

        // fairness: D back-to-back, I holding one request (last = I)
        d_if.read = 1'b1; d_if.addr = 28'h0D00001;
        i_if.read = 1'b1; i_if.addr = 28'h0100001;
        step();
        chk("fair_1_d", mem_if.addr, 28'h0D00001);
        serve(1, 128'h44);
        d_if.addr = 28'h0D00002;
        step();
        step();
        chk("fair_2_i", mem_if.addr, 28'h0100001);
        serve(0, 128'h55);
        i_if.read = 1'b0;
        step();
        step();
        chk("fair_3_d", mem_if.addr, 28'h0D00002);
        serve(2, 128'h66);
        clear_clients();
        step();
        step();

        // illegal read+write executes as a write
        i_if.read = 1'b1; i_if.write = 1'b1; i_if.addr = 28'h0777777; i_if.wdata = 128'h99;
        step();
        chk("illegal_write", mem_if.write, 1'b1);
        chk("illegal_read",  mem_if.read,  1'b0);
        serve(1, 128'h77);
        clear_clients();
        step();
        step();

        // spurious ready in IDLE and in REL
        mem_if.ready = 1'b1;
        step();
        mem_if.ready = 1'b0;
        d_if.read = 1'b1; d_if.addr = 28'h0345678;
        step();
        mem_if.ready = 1'b1;
        step();
        clear_clients();
        step();
        chk("spur_rel_d_ready", d_if.ready, 1'b0);
        mem_if.ready = 1'b0;
        step();

        // reset in the middle of an I transaction
        i_if.read = 1'b1; i_if.addr = 28'h0ABCDEF;
        step();
        step();
        do_reset();
        d_if.read = 1'b1; d_if.addr = 28'h0FEDCBA;
        step();
        chk("post_rst_d_first", mem_if.addr, 28'h0FEDCBA);
        serve(1, 128'h88);
        d_if.read = 1'b0;
        step();
        step();
        chk("post_rst_i_addr", mem_if.addr, 28'h0ABCDEF);
        serve(1, 128'h99);
        clear_clients();
        step();
        step();

        // random traffic
        begin
            int lat = 0;
            int op;
            for (int c = 0; c < 3000; c++) begin
                if (i_done) begin
                    i_if.read = 1'b0; i_if.write = 1'b0;
                end else if (!(i_if.read | i_if.write) && $urandom_range(0, 3) == 0) begin
                    op = $urandom_range(0, 7);
                    i_if.read  = (op < 4) || (op == 7);
                    i_if.write = (op >= 4);
                    i_if.addr  = 28'($urandom());
                    i_if.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                if (d_done) begin
                    d_if.read = 1'b0; d_if.write = 1'b0;
                end else if (!(d_if.read | d_if.write) && $urandom_range(0, 2) == 0) begin
                    op = $urandom_range(0, 7);
                    d_if.read  = (op < 4) || (op == 7);
                    d_if.write = (op >= 4);
                    d_if.addr  = 28'($urandom());
                    d_if.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                if (mem_if.read | mem_if.write) begin
                    if (lat == 0) begin
                        mem_if.ready = 1'b1;
                    end else begin
                        mem_if.ready = 1'b0;
                        lat--;
                    end
                end else begin
                    mem_if.ready = ($urandom_range(0, 7) == 0);
                    lat = $urandom_range(0, 4);
                end
                mem_if.rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single 128-bit line-refill/write-back memory port between the instruction cache and the data cache of the pipelined RISC-V core. Each cache connects through an interface identical to its own memory port: a level request, address and write data, and a one-cycle ready pulse. The arbiter registers the winning command, drives the memory, and routes the memory ready pulse back to the owner only. Arbitration is round-robin; it sits between the two cache instances and the external slow memory.

## Interface
- ADDR_W, 28, line address width (word address [29:2] of a 30-bit processor address)
- DATA_W, 128, line width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_read / i_write  in  1 / 1  I-cache request; level, held until i_ready
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  DATA_W  I-cache write-back data
- i_rdata  out  DATA_W  refill data to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read / d_write / d_addr / d_wdata / d_rdata / d_ready  same as I-cache set, for D-cache
- mem_read / mem_write  out  1 / 1  memory command, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one-cycle pulse
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, GNT_I, GNT_D, REL.
- IDLE: client x requests if x_read|x_write. No request -> stay. One requester -> GNT_x. Both -> the client not granted last (pointer `last`; reset value = I, so D wins the first tie). On the grant edge, latch mem_addr <= x_addr, mem_wdata <= x_wdata, mem_write <= x_write, mem_read <= x_read & ~x_write, and set `last` <= x.
- x_read and x_write both high is illegal and is executed as a write.
- GNT_x: hold the latched command. The client's inputs are not re-sampled. On mem_ready: x_ready = 1 (combinational, same cycle), then -> REL.
- REL: mem_read = mem_write = 0 for exactly one cycle, so the client can drop its request. Always -> IDLE.
- i_rdata = d_rdata = mem_rdata continuously. Only the owner's ready pulses; the non-owner's ready is 0 in every state.
- A client whose request is not granted waits with its request held; it is never dropped. Round-robin guarantees it the next grant.
- mem_ready in IDLE or REL is ignored; no ready is forwarded.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE, last = I, mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, busy = 0. i_ready = d_ready = 0.
- Reset mid-transaction: the command drops immediately and the transaction is abandoned; no ready is issued.
- Request seen high in IDLE at cycle N -> mem_read/mem_write high from cycle N+1.
- mem_ready at cycle M -> x_ready high at M (with mem_rdata); REL at M+1 (mem command low); IDLE at M+2. The earliest next command is at M+3.
- Arbiter latency overhead per transaction is 3 cycles (grant, REL, IDLE) beyond memory latency.
- mem_ready in the grant cycle itself (cycle N+1) is legal and completes the transaction that cycle.

## Test plan
- Single D read: d_read=1, d_addr=0x0000123 at cycle 0; memory returns ready after 4 cycles with rdata=0xDEADBEEF_...  
  -> mem_read=1, mem_addr=0x0000123 from cycle 1; d_ready pulse with d_rdata=rdata; i_ready stays 0; mem_read=0 in REL.
- Simultaneous first requests: i_read and d_write both high after reset  
  -> D is granted first (mem_write=1, mem_addr=d_addr). After its ready+REL, I is granted, with I still asserted throughout.
- Fairness: D requests continuously back-to-back while I holds one request  
  -> grants alternate D, I, D; I never waits more than one D transaction.
- Illegal both-asserted: i_read=i_write=1 -> mem_write=1, mem_read=0.
- Spurious ready: pulse mem_ready in IDLE and in REL -> no i_ready/d_ready; state unchanged except the normal REL->IDLE transition.
- Reset mid-operation: assert rst_n=0 during GNT_I before mem_ready  
  -> mem_read drops asynchronously and busy=0. After release, a fresh I request is granted normally, with D winning any tie.
